axi_master_write: RTL and testbench
===================================

Name: axi_master_write

Overview:
- AXI4 burst write initiator for the DDR path; it is the write-direction companion to the DDR read master.
- It accepts a single burst command (start, address, length), issues one AW transaction, and streams WR_LEN beats of 256-bit data.
- Write data is pulled from a first-word-fall-through (show-ahead) FIFO.
- After the last beat it waits for the B response and then pulses WR_DONE.
- Sits between the frame/line buffer logic and the DDR controller's AXI slave port.

Parameters:
- DATA_W, 256, AXI data width in bits; WSTRB width is DATA_W/8.
- AXI_ID, 4'b0000, constant value driven on AWID.

Ports:
- ACLK  in  1  clock; all logic is on the rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- M_AXI_AWID  out  4  constant AXI_ID.
- M_AXI_AWADDR  out  32  burst start address (registered).
- M_AXI_AWLEN  out  8  burst length minus 1 (registered).
- M_AXI_AWSIZE  out  3  constant 3'b101 (32 bytes per beat).
- M_AXI_AWBURST  out  2  constant 2'b01 (INCR).
- M_AXI_AWVALID  out  1  address valid.
- M_AXI_AWREADY  in  1  address accepted.
- M_AXI_WDATA  out  DATA_W  equals WR_FIFO_DATA (combinational).
- M_AXI_WSTRB  out  DATA_W/8  all ones.
- M_AXI_WLAST  out  1  final beat of the burst.
- M_AXI_WVALID  out  1  data valid.
- M_AXI_WREADY  in  1  data accepted.
- M_AXI_BID  in  4  ignored.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID  in  1  response valid.
- M_AXI_BREADY  out  1  response ready.
- WR_START  in  1  one-cycle burst request; sampled only in IDLE.
- WR_ADRS  in  32  burst address; sampled with WR_START.
- WR_LEN  in  9  beat count, valid range 1..256; sampled with WR_START.
- WR_READY  out  1  high in IDLE.
- WR_FIFO_RE  out  1  FIFO pop strobe.
- WR_FIFO_DATA  in  DATA_W  FIFO head word.
- WR_DONE  out  1  one-cycle pulse when the burst is complete.
- WR_ERR  out  1  set when BRESP != 2'b00; held until the next accepted WR_START.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - AWVALID, WVALID, WLAST, BREADY, WR_DONE, WR_ERR, WR_FIFO_RE = 0.
  - AWADDR = 0, AWLEN = 0, beat counter = 0.
  - WR_READY = 1.
  - Reset mid-burst abandons the transaction with no cleanup; the system resets the slave together with this block.
- States: IDLE, WA_WAIT, WA_START, WD_PROC, WB_WAIT, WR_DONE. State encoding is 3 bits.
- IDLE:
  - WR_START=1 with WR_LEN in 1..256: latch AWADDR=WR_ADRS, AWLEN=WR_LEN-1 (8 bits), beat counter=0, clear WR_ERR, go to WA_WAIT.
  - WR_START with WR_LEN=0 or WR_LEN>256 is ignored; the block stays in IDLE and WR_ERR is unchanged.
- WA_WAIT: one-cycle setup slot; go to WA_START.
- WA_START:
  - AWVALID=1 and is held until the cycle AWREADY=1.
  - On AWVALID&AWREADY: AWVALID<=0, go to WD_PROC.
  - AWVALID is never withdrawn before the handshake.
- WD_PROC:
  - WVALID=1 throughout.
  - WLAST = (beat counter == AWLEN).
  - WR_FIFO_RE = WVALID & WREADY (combinational), so the FIFO pops exactly once per accepted beat.
  - WDATA is stable while WREADY=0.
  - Each handshake increments the beat counter.
  - Handshake with WLAST=1: WVALID<=0, go to WB_WAIT.
  - WR_LEN=1: the first beat carries WLAST.
- WB_WAIT:
  - BREADY=1.
  - On BVALID: WR_ERR <= (BRESP != 2'b00), BREADY<=0, go to WR_DONE.
- WR_DONE: WR_DONE=1 for exactly one cycle, then go to IDLE.
- WR_START outside IDLE is ignored.
- Minimum latency from WR_START to the first AWVALID is 2 cycles.
- The FIFO guarantees the full burst is present before WR_START; no empty handling is performed.
- AW and W are strictly sequential: W never starts before the AW handshake.
- Per-state output levels:
  - AWVALID high only in WA_START.
  - WVALID only in WD_PROC.
  - BREADY only in WB_WAIT.
  - WR_READY only in IDLE.

Test Plan:
- Reset then WR_START, ADRS=0x0000_1000, LEN=16, AWREADY tied 1, WREADY tied 1:
  - AWVALID rises 2 cycles after start, AWLEN=15.
  - 16 consecutive W beats with WLAST on beat 16 only; 16 FIFO pops.
  - BVALID/BRESP=0 gives a 1-cycle WR_DONE, WR_ERR=0.
- LEN=1: single beat with WLAST=1 on beat 1, AWLEN=0.
- LEN=256: AWLEN=255; WLAST on beat 256; counter does not wrap early.
- AWREADY delayed 5 cycles and WREADY toggled 1/0 randomly:
  - AWVALID held steady until the handshake.
  - WDATA stable while WREADY=0.
  - WR_FIFO_RE count = LEN exactly.
- BRESP=2'b10 (SLVERR): WR_ERR=1 after WR_DONE; WR_ERR clears on the next accepted WR_START.
- WR_START pulsed during WD_PROC: ignored, no second AW.
- LEN=0 in IDLE: no state change.
- ARESETN low mid-WD_PROC: all valids drop immediately; IDLE and WR_READY=1 after release.

Source files
------------

// File: rtl/axi_master_write_if.sv
// rtl/axi_master_write_if.sv - AXI4 write-channel bundle (AW, W, B) between write master and DDR slave port
interface axi_master_write_if #(
    parameter int DATA_W = 256
);
    logic [3:0]          awid;
    logic [31:0]         awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [3:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_master_write.sv
// rtl/axi_master_write.sv - single-burst AXI4 write initiator fed from a show-ahead FIFO
module axi_master_write #(
    parameter int         DATA_W = 256,
    parameter logic [3:0] AXI_ID = 4'b0000
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    axi_master_write_if.master   m_axi,
    input  logic                 WR_START,
    input  logic [31:0]          WR_ADRS,
    input  logic [8:0]           WR_LEN,
    output logic                 WR_READY,
    output logic                 WR_FIFO_RE,
    input  logic [DATA_W-1:0]    WR_FIFO_DATA,
    output logic                 WR_DONE,
    output logic                 WR_ERR
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WA_WAIT  = 3'd1,
        S_WA_START = 3'd2,
        S_WD_PROC  = 3'd3,
        S_WB_WAIT  = 3'd4,
        S_WR_DONE  = 3'd5
    } state_t;

    state_t      state;
    logic [31:0] awaddr_q;
    logic [7:0]  awlen_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    // Nine bits so a 256-beat burst can count its final beat without wrapping.
    logic [8:0]  beat_cnt;

    logic        len_ok;
    logic        last_beat;
    logic        unused_bid;

    // Only lengths that fit an AXI4 INCR burst start a transaction.
    assign len_ok    = (WR_LEN != 9'd0) && (WR_LEN <= 9'd256);
    assign last_beat = (beat_cnt == {1'b0, awlen_q});

    assign m_axi.awid    = AXI_ID;
    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awlen   = awlen_q;
    assign m_axi.awsize  = 3'b101;
    assign m_axi.awburst = 2'b01;
    assign m_axi.awvalid = awvalid_q;
    // The FIFO is show-ahead, so its head word is the current beat and stays put until popped.
    assign m_axi.wdata   = WR_FIFO_DATA;
    assign m_axi.wstrb   = '1;
    assign m_axi.wlast   = wvalid_q & last_beat;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign WR_FIFO_RE    = wvalid_q & m_axi.wready;
    assign unused_bid    = ^m_axi.bid;

    // Burst sequencer: command latch, AW handshake, W beats, B response, done pulse.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= S_IDLE;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            beat_cnt  <= '0;
            WR_DONE   <= 1'b0;
            WR_ERR    <= 1'b0;
            WR_READY  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (WR_START && len_ok) begin
                        awaddr_q <= WR_ADRS;
                        awlen_q  <= WR_LEN[7:0] - 8'd1;
                        beat_cnt <= '0;
                        WR_ERR   <= 1'b0;
                        WR_READY <= 1'b0;
                        state    <= S_WA_WAIT;
                    end
                end
                S_WA_WAIT: begin
                    awvalid_q <= 1'b1;
                    state     <= S_WA_START;
                end
                S_WA_START: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state     <= S_WD_PROC;
                    end
                end
                S_WD_PROC: begin
                    if (m_axi.wready) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (last_beat) begin
                            wvalid_q <= 1'b0;
                            bready_q <= 1'b1;
                            state    <= S_WB_WAIT;
                        end
                    end
                end
                S_WB_WAIT: begin
                    if (m_axi.bvalid) begin
                        WR_ERR   <= (m_axi.bresp != 2'b00);
                        bready_q <= 1'b0;
                        WR_DONE  <= 1'b1;
                        state    <= S_WR_DONE;
                    end
                end
                S_WR_DONE: begin
                    WR_DONE  <= 1'b0;
                    WR_READY <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    awvalid_q <= 1'b0;
                    wvalid_q  <= 1'b0;
                    bready_q  <= 1'b0;
                    WR_DONE   <= 1'b0;
                    WR_READY  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_master_write.sv
// tb/tb_axi_master_write.sv - directed table-driven bench for axi_master_write
module tb_axi_master_write;
    localparam int DATA_W = 256;
    localparam int BUDGET = 3000;

    logic              ACLK = 1'b0;
    logic              ARESETN = 1'b0;
    logic              WR_START = 1'b0;
    logic [31:0]       WR_ADRS = '0;
    logic [8:0]        WR_LEN = '0;
    logic              WR_READY;
    logic              WR_FIFO_RE;
    logic [DATA_W-1:0] WR_FIFO_DATA;
    logic              WR_DONE;
    logic              WR_ERR;

    always #5 ACLK = ~ACLK;

    axi_master_write_if #(.DATA_W(DATA_W)) axi ();

    axi_master_write #(.DATA_W(DATA_W), .AXI_ID(4'b0000)) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .m_axi        (axi.master),
        .WR_START     (WR_START),
        .WR_ADRS      (WR_ADRS),
        .WR_LEN       (WR_LEN),
        .WR_READY     (WR_READY),
        .WR_FIFO_RE   (WR_FIFO_RE),
        .WR_FIFO_DATA (WR_FIFO_DATA),
        .WR_DONE      (WR_DONE),
        .WR_ERR       (WR_ERR)
    );

    int total = 0;
    int bad   = 0;
    int fifo_idx = 0;
    int pops = 0;

    function automatic logic [DATA_W-1:0] pat(input int i);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = 32'hA500_0000 + 32'(i * 8 + k);
        return w;
    endfunction

    assign WR_FIFO_DATA = pat(fifo_idx);

    always @(posedge ACLK) begin
        if (WR_FIFO_RE) begin
            fifo_idx <= fifo_idx + 1;
            pops     <= pops + 1;
        end
    end

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] adrs;
        logic [8:0]  len;
        int          aw_delay;
        bit          rand_wready;
        logic [1:0]  bresp;
        logic [7:0]  exp_awlen;
        bit          exp_err;
        bit          extra_start;
    } vec_t;

    task automatic run_burst(input vec_t v);
        int   first_aw = -1, aw_cycles = 0, aw_after = 0, beats = 0, wlast_cnt = 0;
        int   done_cyc = -1, pops0, fifo_base, w_early = 0, re_bad = 0, stab_bad = 0, data_bad = 0, last_bad = 0;
        int   aw_hold_bad = 0;
        bit   aw_done = 0, finished = 0, prev_stall = 0, injected = 0;
        logic s_awvalid, s_wvalid, s_wlast, s_bready, s_done;
        logic [DATA_W-1:0] s_wdata, prev_data;
        @(negedge ACLK);
        chk("ready_before_start", WR_READY, 1);
        fifo_base = fifo_idx;
        pops0     = pops;
        WR_START    = 1'b1;
        WR_ADRS     = v.adrs;
        WR_LEN      = v.len;
        axi.awready = (v.aw_delay == 0);
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        for (int cyc = 1; cyc <= BUDGET; cyc++) begin
            @(negedge ACLK);
            s_awvalid = axi.awvalid;
            s_wvalid  = axi.wvalid;
            s_wlast   = axi.wlast;
            s_wdata   = axi.wdata;
            s_bready  = axi.bready;
            s_done    = WR_DONE;
            WR_START  = 1'b0;
            if (cyc == 1) begin
                chk("busy_after_start", WR_READY, 0);
                chk("err_cleared_on_start", WR_ERR, 0);
                chk("no_awvalid_in_setup", s_awvalid, 0);
            end
            if (v.extra_start && s_wvalid && !injected) begin
                WR_START = 1'b1;
                WR_ADRS  = 32'hDEAD_0000;
                WR_LEN   = 9'd4;
                injected = 1;
            end
            // W channel is checked before AW so a W beat in the AW handshake cycle is caught.
            if (s_wvalid) begin
                if (!aw_done) w_early++;
                if (s_wdata !== pat(fifo_base + beats)) data_bad++;
                if (prev_stall && s_wdata !== prev_data) stab_bad++;
                if (s_wlast !== (beats == int'(v.len) - 1)) last_bad++;
            end
            axi.wready = v.rand_wready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_awvalid) begin
                if (aw_done) aw_after++;
                else begin
                    if (first_aw < 0) first_aw = cyc;
                    aw_cycles++;
                    if (axi.awaddr !== v.adrs || axi.awlen !== v.exp_awlen) aw_hold_bad++;
                    if (v.aw_delay > 0) axi.awready = (cyc >= 2 + v.aw_delay);
                    if (axi.awready) begin
                        aw_done = 1;
                        chk("aw_latency", 32'(first_aw), 32'd2);
                        chk("aw_hold_cycles", 32'(aw_cycles), 32'(v.aw_delay + 1));
                        chk("awaddr", axi.awaddr, v.adrs);
                        chk("awlen", axi.awlen, v.exp_awlen);
                        chk("aw_consts", {axi.awid, axi.awsize, axi.awburst}, {4'h0, 3'b101, 2'b01});
                        chk("wstrb", axi.wstrb, {(DATA_W/8){1'b1}});
                    end
                end
            end
            if (s_bready && !axi.bvalid) begin
                axi.bvalid = 1'b1;
                axi.bresp  = v.bresp;
            end else if (!s_bready) begin
                axi.bvalid = 1'b0;
            end
            #1;
            if (WR_FIFO_RE !== (s_wvalid & axi.wready)) re_bad++;
            prev_stall = s_wvalid & !axi.wready;
            prev_data  = s_wdata;
            if (s_wvalid && axi.wready) begin
                if (s_wlast) wlast_cnt++;
                beats++;
            end
            if (s_done && done_cyc < 0) begin
                done_cyc = cyc;
                chk("err_at_done", WR_ERR, v.exp_err);
                chk("not_ready_at_done", WR_READY, 0);
            end else if (done_cyc > 0 && cyc == done_cyc + 1) begin
                chk("done_pulse_width", s_done, 0);
                chk("ready_after_done", WR_READY, 1);
                chk("err_held", WR_ERR, v.exp_err);
                finished = 1;
                break;
            end
        end
        axi.bvalid = 1'b0;
        chk("burst_finished", finished, 1);
        chk("beat_count", 32'(beats), 32'(v.len));
        chk("wlast_count", 32'(wlast_cnt), 32'd1);
        chk("fifo_pops", 32'(pops - pops0), 32'(v.len));
        chk("second_aw", 32'(aw_after), 32'd0);
        chk("w_before_aw", 32'(w_early), 32'd0);
        chk("wdata_vs_fifo", 32'(data_bad), 32'd0);
        chk("wdata_stable", 32'(stab_bad), 32'd0);
        chk("wlast_position", 32'(last_bad), 32'd0);
        chk("fifo_re_strobe", 32'(re_bad), 32'd0);
        chk("aw_held_steady", 32'(aw_hold_bad), 32'd0);
    endtask

    task automatic ignored_start(input logic [8:0] len, input bit exp_err);
        int moved = 0;
        @(negedge ACLK);
        WR_START = 1'b1;
        WR_ADRS  = 32'h0BAD_0000;
        WR_LEN   = len;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            WR_START = 1'b0;
            if (WR_READY !== 1'b1 || axi.awvalid !== 1'b0 || axi.wvalid !== 1'b0) moved++;
        end
        chk("bad_len_ignored", 32'(moved), 32'd0);
        chk("bad_len_err_kept", WR_ERR, exp_err);
    endtask

    vec_t vecs[5];
    vec_t v;
    int   waited;

    initial begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = 4'h3;

        vecs[0] = '{32'h0000_1000, 9'd16,  0, 1'b0, 2'b00, 8'd15,  1'b0, 1'b0};
        vecs[1] = '{32'h2000_0040, 9'd1,   0, 1'b0, 2'b00, 8'd0,   1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 9'd256, 0, 1'b0, 2'b00, 8'd255, 1'b0, 1'b0};
        vecs[3] = '{32'h0000_3000, 9'd20,  5, 1'b1, 2'b00, 8'd19,  1'b0, 1'b0};
        vecs[4] = '{32'h0000_4000, 9'd3,   1, 1'b1, 2'b10, 8'd2,   1'b1, 1'b0};

        repeat (3) @(negedge ACLK);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_wlast", axi.wlast, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_done_err", {WR_DONE, WR_ERR, WR_FIFO_RE}, 3'b000);
        chk("rst_aw_regs", {axi.awaddr, axi.awlen}, 40'h0);
        chk("rst_wr_ready", WR_READY, 1);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("idle_after_release", WR_READY, 1);

        for (int i = 0; i < 5; i++) run_burst(vecs[i]);

        ignored_start(9'd0, 1'b1);
        ignored_start(9'd257, 1'b1);

        v = '{32'h0000_5000, 9'd6, 0, 1'b0, 2'b00, 8'd5, 1'b0, 1'b1};
        run_burst(v);

        @(negedge ACLK);
        WR_START    = 1'b1;
        WR_ADRS     = 32'h0000_6000;
        WR_LEN      = 9'd8;
        axi.awready = 1'b1;
        axi.wready  = 1'b0;
        waited = 0;
        @(negedge ACLK);
        WR_START = 1'b0;
        while (axi.wvalid !== 1'b1 && waited < 20) begin
            @(negedge ACLK);
            waited++;
        end
        chk("reached_wd_proc", axi.wvalid, 1);
        ARESETN = 1'b0;
        #1;
        chk("rst_mid_valids", {axi.awvalid, axi.wvalid, axi.bready, WR_FIFO_RE}, 4'b0000);
        chk("rst_mid_ready", WR_READY, 1);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        chk("idle_after_mid_reset", {WR_READY, axi.awvalid, axi.wvalid}, 3'b100);

        v = '{32'h0000_7000, 9'd4, 2, 1'b1, 2'b00, 8'd3, 1'b0, 1'b0};
        run_burst(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
